ff_stim_checker: RTL and testbench

Self-checking stimulus driver for the single-bit negedge flip-flops (`d_ff` and `jk_ff` styles). It sits on the opposite side of the flop's interface. It generates pseudo-random D or J/K vectors and drives the flop's reset, then samples Q/Qb and compares them against an internal reference model. It reports pass/fail, an error count and the first failing vector, for use in benches and built-in self-test of flop arrays.

---
 rtl/ff_stim_checker_if.sv | 19 +
 rtl/ff_stim_checker.sv | 156 +++++++++++++++
 tb/tb_ff_stim_checker.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ff_stim_checker_if.sv
// rtl/ff_stim_checker_if.sv - stimulus/response link between checker and flop under test
interface ff_stim_checker_if;
  logic drv_rst_n;
  logic drv_d;
  logic drv_j;
  logic drv_k;
  logic dut_q;
  logic dut_qb;

  modport master (
    output drv_rst_n, drv_d, drv_j, drv_k,
    input  dut_q, dut_qb
  );

  modport slave (
    input  drv_rst_n, drv_d, drv_j, drv_k,
    output dut_q, dut_qb
  );
endinterface

// File: rtl/ff_stim_checker.sv
// rtl/ff_stim_checker.sv - LFSR stimulus driver and reference-model checker for negedge D/JK flops
module ff_stim_checker #(
  parameter int unsigned MODE      = 0,
  parameter int unsigned N_VECTORS = 64,
  parameter logic [7:0]  SEED      = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  ff_stim_checker_if.master        flop,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_pass,
  output logic [7:0]               o_err_count,
  output logic [7:0]               o_first_err_idx
);

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0] LAST_IDX = 8'(N_VECTORS - 1);

  state_t     r_state;
  logic [7:0] r_lfsr;
  logic [7:0] r_idx;
  logic       r_model;
  logic       r_rcnt;
  logic       r_drv_rst_n;
  logic       r_drv_d;
  logic       r_drv_j;
  logic       r_drv_k;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [7:0] r_err_count;
  logic [7:0] r_first_err_idx;

  logic [7:0] w_lfsr_next;
  logic       w_model_next;
  logic       w_run_err;
  logic       w_rst_err;
  logic       w_err_sat;

  // Model is advanced with the vector currently on the drive lines, i.e. the one the flop just captured.
  always_comb begin
    w_lfsr_next  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    w_model_next = r_model;
    if (MODE == 0) begin
      w_model_next = r_drv_d;
    end else begin
      case ({r_drv_j, r_drv_k})
        2'b00:   w_model_next = r_model;
        2'b01:   w_model_next = 1'b0;
        2'b10:   w_model_next = 1'b1;
        default: w_model_next = ~r_model;
      endcase
    end
    w_run_err = (flop.dut_q != w_model_next) || (flop.dut_qb != ~w_model_next);
    w_rst_err = (flop.dut_q != 1'b0) || (flop.dut_qb != 1'b1);
    w_err_sat = (r_err_count == 8'hFF);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_lfsr          <= SEED_EFF;
      r_idx           <= 8'd0;
      r_model         <= 1'b0;
      r_rcnt          <= 1'b0;
      r_drv_rst_n     <= 1'b0;
      r_drv_d         <= 1'b0;
      r_drv_j         <= 1'b0;
      r_drv_k         <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_err_count     <= 8'd0;
      r_first_err_idx <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (r_state == S_IDLE) r_drv_rst_n <= 1'b1;
          if (i_start) begin
            r_state         <= S_RESET;
            r_drv_rst_n     <= 1'b0;
            r_drv_d         <= 1'b0;
            r_drv_j         <= 1'b0;
            r_drv_k         <= 1'b0;
            r_busy          <= 1'b1;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_err_count     <= 8'd0;
            r_first_err_idx <= 8'd0;
            r_lfsr          <= SEED_EFF;
            r_idx           <= 8'd0;
            r_model         <= 1'b0;
            r_rcnt          <= 1'b0;
          end
        end
        S_RESET: begin
          if (!r_rcnt) begin
            r_rcnt <= 1'b1;
          end else begin
            if (w_rst_err) begin
              r_err_count     <= 8'd1;
              r_first_err_idx <= 8'hFF;
            end
            r_drv_rst_n <= 1'b1;
            if (MODE == 0) begin
              r_drv_d <= r_lfsr[0];
            end else begin
              r_drv_j <= r_lfsr[0];
              r_drv_k <= r_lfsr[1];
            end
            r_lfsr  <= w_lfsr_next;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_model <= w_model_next;
          if (w_run_err) begin
            if (!w_err_sat) r_err_count <= r_err_count + 8'd1;
            if (r_err_count == 8'd0) r_first_err_idx <= r_idx;
          end
          if (r_idx == LAST_IDX) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_err_count == 8'd0) && !w_run_err;
          end else begin
            if (MODE == 0) begin
              r_drv_d <= r_lfsr[0];
            end else begin
              r_drv_j <= r_lfsr[0];
              r_drv_k <= r_lfsr[1];
            end
            r_lfsr <= w_lfsr_next;
            r_idx  <= r_idx + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign flop.drv_rst_n  = r_drv_rst_n;
  assign flop.drv_d      = r_drv_d;
  assign flop.drv_j      = r_drv_j;
  assign flop.drv_k      = r_drv_k;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_pass          = r_pass;
  assign o_err_count     = r_err_count;
  assign o_first_err_idx = r_first_err_idx;

endmodule

// File: tb/tb_ff_stim_checker.sv
// tb/tb_ff_stim_checker.sv - randomized self-checking bench for ff_stim_checker
module tb_ff_stim_checker;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Units: 0 = D/64 (fault-selectable), 1 = JK/64, 2 = D/255 on an inverting flop, 3 = D/1 (fault-selectable)
  logic [3:0] start = 4'b0;
  logic [3:0] busy, done, pass;
  logic [7:0] errc [4];
  logic [7:0] ferr [4];
  int fault = 0;

  ff_stim_checker_if if_d ();
  ff_stim_checker_if if_j ();
  ff_stim_checker_if if_s ();
  ff_stim_checker_if if_b ();

  ff_stim_checker #(.MODE(0), .N_VECTORS(64), .SEED(8'hA5)) u_d (
    .clk(clk), .rst(rst), .i_start(start[0]), .flop(if_d),
    .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0]),
    .o_err_count(errc[0]), .o_first_err_idx(ferr[0]));
  ff_stim_checker #(.MODE(1), .N_VECTORS(64), .SEED(8'hA5)) u_j (
    .clk(clk), .rst(rst), .i_start(start[1]), .flop(if_j),
    .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1]),
    .o_err_count(errc[1]), .o_first_err_idx(ferr[1]));
  ff_stim_checker #(.MODE(0), .N_VECTORS(255), .SEED(8'hA5)) u_s (
    .clk(clk), .rst(rst), .i_start(start[2]), .flop(if_s),
    .o_busy(busy[2]), .o_done(done[2]), .o_pass(pass[2]),
    .o_err_count(errc[2]), .o_first_err_idx(ferr[2]));
  ff_stim_checker #(.MODE(0), .N_VECTORS(1), .SEED(8'hA5)) u_b (
    .clk(clk), .rst(rst), .i_start(start[3]), .flop(if_b),
    .o_busy(busy[3]), .o_done(done[3]), .o_pass(pass[3]),
    .o_err_count(errc[3]), .o_first_err_idx(ferr[3]));

  // Flops under test: negedge capture, async active-low reset
  logic q_d, q_j, q_s, q_b;
  always @(negedge clk or negedge if_d.drv_rst_n)
    if (!if_d.drv_rst_n) q_d <= 1'b0; else q_d <= if_d.drv_d;
  always @(negedge clk or negedge if_j.drv_rst_n)
    if (!if_j.drv_rst_n) q_j <= 1'b0;
    else if (if_j.drv_j && if_j.drv_k) q_j <= ~q_j;
    else if (if_j.drv_j) q_j <= 1'b1;
    else if (if_j.drv_k) q_j <= 1'b0;
  always @(negedge clk or negedge if_s.drv_rst_n)
    if (!if_s.drv_rst_n) q_s <= 1'b1; else q_s <= ~if_s.drv_d;
  always @(negedge clk or negedge if_b.drv_rst_n)
    if (!if_b.drv_rst_n) q_b <= 1'b0; else q_b <= if_b.drv_d;

  assign if_d.dut_q  = (fault == 1) ? 1'b0 : q_d;
  assign if_d.dut_qb = (fault == 1) ? 1'b1 : ~q_d;
  assign if_j.dut_q  = q_j;
  assign if_j.dut_qb = ~q_j;
  assign if_s.dut_q  = q_s;
  assign if_s.dut_qb = ~q_s;
  assign if_b.dut_q  = (fault == 1) ? 1'b0 : q_b;
  assign if_b.dut_qb = (fault == 1) ? 1'b1 : ~q_b;

  logic [3:0] drv_d_all, drv_j_all, drv_k_all, drv_rst_all;
  assign drv_d_all   = {if_b.drv_d, if_s.drv_d, if_j.drv_d, if_d.drv_d};
  assign drv_j_all   = {if_b.drv_j, if_s.drv_j, if_j.drv_j, if_d.drv_j};
  assign drv_k_all   = {if_b.drv_k, if_s.drv_k, if_j.drv_k, if_d.drv_k};
  assign drv_rst_all = {if_b.drv_rst_n, if_s.drv_rst_n, if_j.drv_rst_n, if_d.drv_rst_n};

  logic [7:0] exp_s [256];
  logic       obs_d [256];
  logic       obs_j [256];
  logic       obs_k [256];

  // Reference: walk the vector list, track what the flop should hold, and what the faulty flop shows.
  function automatic void ref_run(input int mode, input int n, input int flt,
                                  output int errs, output int first);
    int  raw;
    logic model, q, j, k;
    raw = 0; first = 0; model = 1'b0;
    if (flt == 2) begin raw = 1; first = 255; end
    for (int i = 0; i < n; i++) begin
      j = exp_s[i][0];
      k = exp_s[i][1];
      if (mode == 0) model = j;
      else if (j && k) model = ~model;
      else if (j) model = 1'b1;
      else if (k) model = 1'b0;
      q = (flt == 1) ? 1'b0 : (flt == 2) ? ~model : model;
      if (q != model) begin
        if (raw == 0) first = i;
        raw++;
      end
    end
    errs = (raw > 255) ? 255 : raw;
  endfunction

  task automatic run_unit(input int u, input int n, input bit spur, output int cyc, output bit tmo);
    @(negedge clk); start[u] = 1'b1;
    @(negedge clk); start[u] = 1'b0;
    cyc = 0; tmo = 1'b0;
    while (done[u] !== 1'b1) begin
      if (cyc >= 2 && cyc <= n + 1) begin
        obs_d[cyc-2] = drv_d_all[u];
        obs_j[cyc-2] = drv_j_all[u];
        obs_k[cyc-2] = drv_k_all[u];
      end
      if (cyc >= 1000) begin tmo = 1'b1; break; end
      start[u] = (spur && busy[u] && $urandom_range(0, 3) == 0);
      @(negedge clk); cyc++;
    end
    start[u] = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(1, 5)) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (busy[0] !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy[0]); end
    n_vec++; if (done[0] !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done[0]); end
    n_vec++; if (pass[0] !== 1'b0) begin n_err++; $display("FAIL reset_pass: got %b expected 0", pass[0]); end
    n_vec++; if (errc[0] !== 8'd0) begin n_err++; $display("FAIL reset_err: got %0d expected 0", errc[0]); end
    n_vec++; if (ferr[0] !== 8'd0) begin n_err++; $display("FAIL reset_first: got %0d expected 0", ferr[0]); end
    n_vec++; if (drv_rst_all !== 4'b0) begin n_err++; $display("FAIL reset_drv_rst_n: got %b expected 0000", drv_rst_all); end
    n_vec++; if ({drv_d_all, drv_j_all, drv_k_all} !== 12'b0) begin n_err++; $display("FAIL reset_stim: got %h expected 000", {drv_d_all, drv_j_all, drv_k_all}); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (drv_rst_all !== 4'hF) begin n_err++; $display("FAIL idle_drv_rst_n: got %b expected 1111", drv_rst_all); end
  endtask

  task automatic test_d_correct();
    int cyc, e, f; bit tmo; int bad;
    fault = 0;
    run_unit(0, 64, 1'b1, cyc, tmo);
    ref_run(0, 64, 0, e, f);
    n_vec++; if (tmo || cyc != 66) begin n_err++; $display("FAIL d_done_time: got %0d expected 66", cyc); end
    n_vec++; if (pass[0] !== 1'b1) begin n_err++; $display("FAIL d_pass: got %b expected 1", pass[0]); end
    n_vec++; if (errc[0] !== 8'(e)) begin n_err++; $display("FAIL d_err: got %0d expected %0d", errc[0], e); end
    n_vec++; if (busy[0] !== 1'b0) begin n_err++; $display("FAIL d_busy_done: got %b expected 0", busy[0]); end
    bad = 0;
    for (int i = 0; i < 64; i++) if (obs_d[i] !== exp_s[i][0] || obs_j[i] !== 1'b0) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL d_stim_seq: got %0d bad vectors expected 0", bad); end
  endtask

  task automatic test_jk_correct();
    int cyc, e, f; bit tmo; int bad;
    run_unit(1, 64, 1'b0, cyc, tmo);
    ref_run(1, 64, 0, e, f);
    n_vec++; if (tmo || cyc != 66) begin n_err++; $display("FAIL jk_done_time: got %0d expected 66", cyc); end
    n_vec++; if (pass[1] !== 1'b1) begin n_err++; $display("FAIL jk_pass: got %b expected 1", pass[1]); end
    n_vec++; if (errc[1] !== 8'(e)) begin n_err++; $display("FAIL jk_err: got %0d expected %0d", errc[1], e); end
    n_vec++; if ({obs_j[0], obs_k[0]} !== 2'b10) begin n_err++; $display("FAIL jk_first_vec: got %b%b expected 10", obs_j[0], obs_k[0]); end
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (obs_j[i] !== exp_s[i][0] || obs_k[i] !== exp_s[i][1] || obs_d[i] !== 1'b0) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL jk_stim_seq: got %0d bad vectors expected 0", bad); end
  endtask

  task automatic test_stuck0();
    int cyc, e, f; bit tmo;
    fault = 1;
    run_unit(0, 64, 1'b0, cyc, tmo);
    ref_run(0, 64, 1, e, f);
    n_vec++; if (tmo || cyc != 66) begin n_err++; $display("FAIL s0_done_time: got %0d expected 66", cyc); end
    n_vec++; if (errc[0] !== 8'(e)) begin n_err++; $display("FAIL s0_err: got %0d expected %0d", errc[0], e); end
    n_vec++; if (ferr[0] !== 8'(f)) begin n_err++; $display("FAIL s0_first: got %0d expected %0d", ferr[0], f); end
    n_vec++; if (pass[0] !== 1'b0) begin n_err++; $display("FAIL s0_pass: got %b expected 0", pass[0]); end
    fault = 0;
  endtask

  task automatic test_saturation();
    int cyc, e, f; bit tmo;
    run_unit(2, 255, 1'b1, cyc, tmo);
    ref_run(0, 255, 2, e, f);
    n_vec++; if (tmo || cyc != 257) begin n_err++; $display("FAIL sat_done_time: got %0d expected 257", cyc); end
    n_vec++; if (errc[2] !== 8'(e)) begin n_err++; $display("FAIL sat_err: got %0d expected %0d", errc[2], e); end
    n_vec++; if (ferr[2] !== 8'(f)) begin n_err++; $display("FAIL sat_first: got %0d expected %0d", ferr[2], f); end
    n_vec++; if (pass[2] !== 1'b0) begin n_err++; $display("FAIL sat_pass: got %b expected 0", pass[2]); end
  endtask

  task automatic test_back_to_back();
    int cyc, e, f; bit tmo;
    fault = 1;
    run_unit(3, 1, 1'b0, cyc, tmo);
    ref_run(0, 1, 1, e, f);
    n_vec++; if (tmo || cyc != 3) begin n_err++; $display("FAIL b1_done_time: got %0d expected 3", cyc); end
    n_vec++; if (errc[3] !== 8'(e)) begin n_err++; $display("FAIL b1_err: got %0d expected %0d", errc[3], e); end
    n_vec++; if (ferr[3] !== 8'(f)) begin n_err++; $display("FAIL b1_first: got %0d expected %0d", ferr[3], f); end
    n_vec++; if (pass[3] !== 1'b0) begin n_err++; $display("FAIL b1_pass: got %b expected 0", pass[3]); end
    start[3] = 1'b1;
    @(negedge clk);
    start[3] = 1'b0;
    fault = 0;
    n_vec++; if ({busy[3], done[3], pass[3]} !== 3'b100) begin n_err++; $display("FAIL b2_restart_flags: got %b expected 100", {busy[3], done[3], pass[3]}); end
    n_vec++; if (errc[3] !== 8'd0) begin n_err++; $display("FAIL b2_err_cleared: got %0d expected 0", errc[3]); end
    n_vec++; if (drv_rst_all[3] !== 1'b0) begin n_err++; $display("FAIL b2_drv_rst_n: got %b expected 0", drv_rst_all[3]); end
    cyc = 0;
    while (done[3] !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    n_vec++; if (cyc != 3) begin n_err++; $display("FAIL b2_done_time: got %0d expected 3", cyc); end
    n_vec++; if (pass[3] !== 1'b1 || errc[3] !== 8'd0) begin n_err++; $display("FAIL b2_pass: got %b/%0d expected 1/0", pass[3], errc[3]); end
  endtask

  task automatic test_async_abort();
    fault = 0;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      start[0] = ($urandom_range(0, 1) == 1);
      @(negedge clk);
    end
    start[0] = 1'b0;
    n_vec++; if (busy[0] !== 1'b1) begin n_err++; $display("FAIL ab_busy_mid: got %b expected 1", busy[0]); end
    #2 rst = 1'b0;
    #1;
    n_vec++; if ({busy[0], done[0], pass[0]} !== 3'b000) begin n_err++; $display("FAIL ab_flags: got %b expected 000", {busy[0], done[0], pass[0]}); end
    n_vec++; if (errc[0] !== 8'd0 || ferr[0] !== 8'd0) begin n_err++; $display("FAIL ab_counts: got %0d/%0d expected 0/0", errc[0], ferr[0]); end
    n_vec++; if ({drv_rst_all[0], drv_d_all[0]} !== 2'b00) begin n_err++; $display("FAIL ab_drv: got %b expected 00", {drv_rst_all[0], drv_d_all[0]}); end
    @(negedge clk); rst = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++; if ({busy[0], done[0], drv_rst_all[0]} !== 3'b001) begin n_err++; $display("FAIL ab_stays_idle: got %b expected 001", {busy[0], done[0], drv_rst_all[0]}); end
  endtask

  initial begin
    logic [7:0] s;
    s = 8'hA5;
    for (int i = 0; i < 256; i++) begin
      exp_s[i] = s;
      s = {s[6:0], ^(s & 8'hB8)};
    end
    test_reset();
    gap(); test_d_correct();
    gap(); test_jk_correct();
    gap(); test_stuck0();
    gap(); test_saturation();
    gap(); test_back_to_back();
    gap(); test_async_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
